// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller for the SimpleMIPS datapath: decodes the IR opcode/funct
// and sequences fetch, decode, execute, memory and write-back with a memory wait timeout.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUCtrl,
  output logic [1:0] ExtOp,
  output logic [2:0] State,
  output logic       Illegal,
  output logic       MemTimeout
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_J} class_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_SLT   = 3'd4,
    ALU_PASSB = 3'd5
  } alu_t;

  typedef enum logic [1:0] {
    EXT_ZERO    = 2'd0,
    EXT_SIGNED  = 2'd1,
    EXT_HIGHPOS = 2'd2
  } ext_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t     r_state;
  class_t     r_class;
  alu_t       r_alufn;
  ext_t       r_ext;
  logic [7:0] r_cnt;

  class_t w_class;
  alu_t   w_alufn;
  ext_t   w_ext;
  logic   w_legal;
  logic   w_tmo;

  always_comb begin
    w_legal = 1'b1;
    w_class = C_RALU;
    w_alufn = ALU_ADD;
    w_ext   = EXT_SIGNED;
    case (Op)
      6'b000000: begin
        case (Funct)
          6'b100001: w_alufn = ALU_ADD;
          6'b100011: w_alufn = ALU_SUB;
          6'b100100: w_alufn = ALU_AND;
          6'b100101: w_alufn = ALU_OR;
          6'b101010: w_alufn = ALU_SLT;
          default:   w_legal = 1'b0;
        endcase
      end
      6'b001001: w_class = C_IALU;
      6'b001101: begin
        w_class = C_IALU;
        w_alufn = ALU_OR;
        w_ext   = EXT_ZERO;
      end
      6'b001111: begin
        w_class = C_IALU;
        w_alufn = ALU_PASSB;
        w_ext   = EXT_HIGHPOS;
      end
      6'b100011: w_class = C_LW;
      6'b101011: w_class = C_SW;
      6'b000100: w_class = C_BEQ;
      6'b000010: w_class = C_J;
      default:   w_legal = 1'b0;
    endcase
  end

  // A ready on the limit cycle is a completion, so the abort needs MemReady low.
  assign w_tmo = ((r_state == S_FETCH) || (r_state == S_MEM)) && !MemReady && (r_cnt == TMO);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_FETCH;
      r_class <= C_RALU;
      r_alufn <= ALU_ADD;
      r_ext   <= EXT_SIGNED;
      r_cnt   <= '0;
    end else begin
      r_cnt <= '0;
      case (r_state)
        S_FETCH: begin
          if (MemReady)   r_state <= S_DECODE;
          else if (w_tmo) r_state <= S_FETCH;
          else            r_cnt   <= r_cnt + 8'd1;
        end
        S_DECODE: begin
          if (w_legal) begin
            r_class <= w_class;
            r_alufn <= w_alufn;
            r_ext   <= w_ext;
            case (w_class)
              C_BEQ:   r_state <= S_BRANCH;
              C_J:     r_state <= S_JUMP;
              default: r_state <= S_EXEC;
            endcase
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_EXEC: r_state <= ((r_class == C_LW) || (r_class == C_SW)) ? S_MEM : S_WB;
        S_MEM: begin
          if (MemReady)   r_state <= (r_class == C_LW) ? S_WB : S_FETCH;
          else if (w_tmo) r_state <= S_FETCH;
          else            r_cnt   <= r_cnt + 8'd1;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    PCSrc      = 2'b00;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUCtrl    = ALU_ADD;
    ExtOp      = EXT_SIGNED;
    Illegal    = 1'b0;
    MemTimeout = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead    = !w_tmo;
        ALUSrcB    = 2'b01;
        IRWrite    = MemReady;
        PCWrite    = MemReady;
        MemTimeout = w_tmo;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        Illegal = !w_legal;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = (r_class == C_RALU) ? 2'b00 : 2'b10;
        ALUCtrl = r_alufn;
        ExtOp   = r_ext;
      end
      S_MEM: begin
        IorD       = 1'b1;
        MemRead    = (r_class == C_LW) && !w_tmo;
        MemWrite   = (r_class == C_SW) && !w_tmo;
        MemTimeout = w_tmo;
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = (r_class == C_RALU);
        MemToReg = (r_class == C_LW);
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUCtrl = ALU_SUB;
        PCSrc   = 2'b01;
        PCWrite = Zero;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    // Strobes are gated by reset directly so they drop the instant rstn falls.
    if (!rstn) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      Illegal    = 1'b0;
      MemTimeout = 1'b0;
    end
  end

  assign State = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected output vectors are queued
// for each instruction and compared against the DUT at the falling edge.
module tb_multicycle_ctrl;
  localparam int unsigned TO = 15;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;
  localparam logic [31:0] RST_EXP = {9'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 2'b01, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [5:0] Op = '0;
  logic [5:0] Funct = '0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemToReg;
  logic       ALUSrcA, Illegal, MemTimeout;
  logic [1:0] PCSrc, ALUSrcB, ExtOp;
  logic [2:0] ALUCtrl, State;
  logic [31:0] w_obs;

  multicycle_ctrl #(.TIMEOUT(TO)) u_dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl), .ExtOp(ExtOp),
    .State(State), .Illegal(Illegal), .MemTimeout(MemTimeout)
  );

  always #5 clk = ~clk;

  assign w_obs = {9'b0, State, PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite, RegWrite,
                  RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUCtrl, ExtOp, Illegal, MemTimeout};

  typedef struct {
    logic [31:0] exp;
    logic        rdy;
    logic        zero;
  } ent_t;

  ent_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expv(input int st, input int kind, input logic [2:0] ctrl,
                                       input logic [1:0] ext, input logic rdy, input logic zero,
                                       input logic tmo);
    logic pcw, irw, iord, mr, mw, rw, rd, m2r, asa, ill;
    logic [1:0] pcsrc, asb, ex;
    logic [2:0] ac;
    {pcw, irw, iord, mr, mw, rw, rd, m2r, asa, ill} = '0;
    pcsrc = 2'b00; asb = 2'b00; ac = 3'b000; ex = 2'b01;
    case (st)
      0: begin mr = !tmo; asb = 2'b01; irw = rdy; pcw = rdy; end
      1: begin asb = 2'b11; ill = (kind == K_ILL); end
      2: begin asa = 1'b1; asb = (kind == K_R) ? 2'b00 : 2'b10; ac = ctrl; ex = ext; end
      3: begin iord = 1'b1; mr = (kind == K_LW) && !tmo; mw = (kind == K_SW) && !tmo; end
      4: begin rw = 1'b1; rd = (kind == K_R); m2r = (kind == K_LW); end
      5: begin asa = 1'b1; ac = 3'b001; pcsrc = 2'b01; pcw = zero; end
      6: begin pcsrc = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    return {9'b0, 3'(st), pcw, pcsrc, irw, iord, mr, mw, rw, rd, m2r, asa, asb, ac, ex, ill, tmo};
  endfunction

  task automatic push(input int st, input int kind, input logic [2:0] ctrl, input logic [1:0] ext,
                      input logic rdy, input logic zero, input logic tmo);
    ent_t e;
    e.exp  = expv(st, kind, ctrl, ext, rdy, zero, tmo);
    e.rdy  = rdy;
    e.zero = zero;
    sbq.push_back(e);
  endtask

  // Entered and left at posedge+1; each entry is one clock.
  task automatic drain(input string name);
    int c = 0;
    while (sbq.size() > 0) begin
      ent_t e;
      e = sbq.pop_front();
      MemReady = e.rdy;
      Zero     = e.zero;
      @(negedge clk);
      chk($sformatf("%s c%0d", name, c), w_obs, e.exp);
      c++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input int kind, input logic [2:0] ctrl, input logic [1:0] ext,
                          input logic zero, input int fwait, input int mwait);
    int w = 0;
    bit aborted = 1'b0;
    Op = op;
    Funct = fn;
    for (int k = 0; k < fwait; k++) begin
      if (w == int'(TO)) begin push(0, kind, ctrl, ext, 1'b0, zero, 1'b1); w = 0; end
      else begin push(0, kind, ctrl, ext, 1'b0, zero, 1'b0); w++; end
    end
    push(0, kind, ctrl, ext, 1'b1, zero, 1'b0);
    push(1, kind, ctrl, ext, 1'b0, zero, 1'b0);
    if (kind == K_BEQ) push(5, kind, ctrl, ext, 1'b0, zero, 1'b0);
    else if (kind == K_J) push(6, kind, ctrl, ext, 1'b0, zero, 1'b0);
    else if (kind != K_ILL) begin
      push(2, kind, ctrl, ext, 1'b0, zero, 1'b0);
      if (kind == K_LW || kind == K_SW) begin
        w = 0;
        for (int k = 0; k < mwait; k++) begin
          if (!aborted) begin
            if (w == int'(TO)) begin push(3, kind, ctrl, ext, 1'b0, zero, 1'b1); aborted = 1'b1; end
            else begin push(3, kind, ctrl, ext, 1'b0, zero, 1'b0); w++; end
          end
        end
        if (!aborted) begin
          push(3, kind, ctrl, ext, 1'b1, zero, 1'b0);
          if (kind == K_LW) push(4, kind, ctrl, ext, 1'b0, zero, 1'b0);
        end
      end else begin
        push(4, kind, ctrl, ext, 1'b0, zero, 1'b0);
      end
    end
    drain(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #12;
    chk("reset", w_obs, RST_EXP);
    MemReady = 1'b1;
    #1;
    chk("reset_rdy", w_obs, RST_EXP);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    do_instr("lui",   6'b001111, 6'b000000, K_I,   3'b101, 2'b10, 1'b0, 0, 0);
    do_instr("ori",   6'b001101, 6'b000000, K_I,   3'b011, 2'b00, 1'b0, 0, 0);
    do_instr("addiu", 6'b001001, 6'b000000, K_I,   3'b000, 2'b01, 1'b0, 0, 0);
    do_instr("addu",  6'b000000, 6'b100001, K_R,   3'b000, 2'b01, 1'b0, 0, 0);
    do_instr("subu",  6'b000000, 6'b100011, K_R,   3'b001, 2'b01, 1'b0, 1, 0);
    do_instr("and",   6'b000000, 6'b100100, K_R,   3'b010, 2'b01, 1'b0, 0, 0);
    do_instr("or",    6'b000000, 6'b100101, K_R,   3'b011, 2'b01, 1'b0, 0, 0);
    do_instr("slt",   6'b000000, 6'b101010, K_R,   3'b100, 2'b01, 1'b0, 2, 0);
    do_instr("lw_w3", 6'b100011, 6'b000000, K_LW,  3'b000, 2'b01, 1'b0, 0, 3);
    do_instr("sw",    6'b101011, 6'b000000, K_SW,  3'b000, 2'b01, 1'b0, 0, 0);
    do_instr("sw_w2", 6'b101011, 6'b000000, K_SW,  3'b000, 2'b01, 1'b0, 0, 2);
    do_instr("beq_z1", 6'b000100, 6'b000000, K_BEQ, 3'b000, 2'b01, 1'b1, 0, 0);
    do_instr("beq_z0", 6'b000100, 6'b000000, K_BEQ, 3'b000, 2'b01, 1'b0, 0, 0);
    do_instr("j",     6'b000010, 6'b000000, K_J,   3'b000, 2'b01, 1'b0, 0, 0);
    do_instr("ill_r", 6'b000000, 6'b000000, K_ILL, 3'b000, 2'b01, 1'b0, 0, 0);
    do_instr("ill_op", 6'b111111, 6'b100001, K_ILL, 3'b000, 2'b01, 1'b0, 0, 0);
    do_instr("f_tmo", 6'b001001, 6'b000000, K_I,   3'b000, 2'b01, 1'b0, 17, 0);
    do_instr("f_edge", 6'b001101, 6'b000000, K_I,  3'b011, 2'b00, 1'b0, int'(TO), 0);
    do_instr("m_tmo", 6'b100011, 6'b000000, K_LW,  3'b000, 2'b01, 1'b0, 0, 16);
    do_instr("m_edge", 6'b100011, 6'b000000, K_LW, 3'b000, 2'b01, 1'b0, 0, int'(TO));

    Op = 6'b101011;
    Funct = '0;
    push(0, K_SW, 3'b000, 2'b01, 1'b1, 1'b0, 1'b0);
    push(1, K_SW, 3'b000, 2'b01, 1'b0, 1'b0, 1'b0);
    push(2, K_SW, 3'b000, 2'b01, 1'b0, 1'b0, 1'b0);
    push(3, K_SW, 3'b000, 2'b01, 1'b0, 1'b0, 1'b0);
    drain("sw_rst");
    #2;
    chk("sw_mem_hold", w_obs, expv(3, K_SW, 3'b000, 2'b01, 1'b0, 1'b0, 1'b0));
    rstn = 1'b0;
    #1;
    chk("sw_rst_async", w_obs, RST_EXP);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    do_instr("lui_after_rst", 6'b001111, 6'b000000, K_I, 3'b101, 2'b10, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main controller for the SimpleMIPS datapath. It decodes the instruction held in the IR and sequences fetch, decode, execute, memory and write-back over several clocks. On every cycle it drives the immediate extender's ExtOp, the ALU operand and function selects, PC/IR/register-file write enables and memory strobes. It handshakes with instruction/data memory through a single ready line, and a wait-cycle counter aborts stalled accesses.

## Interface
- TIMEOUT, 15: maximum wait cycles for MemReady in FETCH or MEM before abort (1..255).
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- Op  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  PC load enable.
- PCSrc  out  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target.
- IRWrite  out  1  IR load enable.
- IorD  out  1  0 = address from PC, 1 = address from ALUOut.
- MemRead, MemWrite  out  1 each  memory strobes.
- RegWrite  out  1  register file write enable.
- RegDst  out  1  1 = rd, 0 = rt.
- MemToReg  out  1  1 = write MDR, 0 = write ALUOut.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 rt, 01 constant 4, 10 Imm32, 11 Imm32<<2.
- ALUCtrl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 PASSB.
- ExtOp  out  2  EXT_ZERO 00, EXT_SIGNED 01, EXT_HIGHPOS 10.
- State  out  3  current state, for debug.
- Illegal  out  1  one-cycle pulse on an unsupported opcode/funct.
- MemTimeout  out  1  one-cycle pulse on a memory abort.

## Operation
- Supported instructions:
  - R-type (Op 000000) with Funct: addu 100001, subu 100011, and 100100, or 100101, slt 101010.
  - I-type: addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100.
  - J-type: j 000010.
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, BRANCH 5, JUMP 6.
- Outputs are a Moore decode of the state register plus a class register. PCWrite in BRANCH (gated by Zero) and the MemReady-qualified strobes are the only Mealy terms.
- Unlisted outputs are 0, except ExtOp, which defaults to EXT_SIGNED.
- FETCH:
  - Drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtrl=ADD, PCSrc=00.
  - IRWrite and PCWrite assert only in the cycle MemReady=1; that cycle also moves to DECODE.
- DECODE:
  - Drive ALUSrcA=0, ALUSrcB=11, ExtOp=SIGNED, ALUCtrl=ADD, so the branch target lands in ALUOut.
  - Latch the instruction class (RALU, IALU, LW, SW, BEQ, J) and the ALU function.
  - Next state: BEQ→BRANCH, J→JUMP, otherwise EXEC.
  - Illegal encoding: pulse Illegal and return to FETCH. No writes occur.
- EXEC:
  - Drive ALUSrcA=1.
  - RALU: ALUSrcB=00, ALUCtrl from Funct.
  - addiu/lw/sw: ALUSrcB=10, ExtOp=SIGNED, ADD.
  - ori: ALUSrcB=10, ExtOp=ZERO, OR.
  - lui: ALUSrcB=10, ExtOp=HIGHPOS, PASSB.
  - Next state: LW/SW→MEM, else WB.
- MEM:
  - Drive IorD=1, with MemRead (LW) or MemWrite (SW).
  - Wait for MemReady=1; then LW→WB and SW→FETCH.
- WB:
  - Drive RegWrite=1, RegDst=1 for RALU else 0, MemToReg=1 for LW.
  - Next state: FETCH.
- BRANCH:
  - Drive ALUSrcA=1, ALUSrcB=00, ALUCtrl=SUB, PCSrc=01, PCWrite=Zero.
  - Next state: FETCH.
- JUMP:
  - Drive PCSrc=10, PCWrite=1.
  - Next state: FETCH.
- Wait counter (8 bits):
  - Clears on entry to FETCH or MEM, and whenever MemReady=1.
  - Increments each waiting cycle.
  - When the count equals TIMEOUT with MemReady=0: pulse MemTimeout, drop the strobes that cycle, and go to FETCH. The counter clears.
  - In FETCH the abort re-issues the same PC, since PCWrite was never asserted.
- MemReady=1 on the same cycle the count reaches TIMEOUT counts as completion, not timeout.

## Timing
- Reset (rstn=0), taking effect immediately and asynchronously:
  - State=FETCH, class register=RALU, counter=0.
  - While rstn=0 all strobes are forced 0: PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Illegal, MemTimeout.
  - Selects take their FETCH values; ExtOp=EXT_SIGNED.
- Reset mid-instruction abandons it with no further writes. The first cycle after release is FETCH.
- Cycle counts with zero wait states (MemReady=1 on the first cycle):
  - RALU/IALU: 4.
  - lw: 5.
  - sw: 4.
  - beq: 3.
  - j: 3.
  - illegal: 2.
- Each wait cycle adds one cycle.
- ExtOp changes only at state boundaries and is valid for the full EXEC cycle.

## Test plan
- Reset then release, MemReady=1, Op=001111 (lui): States 0,1,2,4. In EXEC, ExtOp=10, ALUCtrl=101, ALUSrcB=10. In WB, RegWrite=1, RegDst=0.
- ori (001101) then addiu (001001): ExtOp=00 in the first EXEC and 01 in the second. Each instruction takes 4 cycles.
- lw with MemReady low for 3 cycles in MEM: MEM lasts 4 cycles with MemRead and IorD held. Then WB with MemToReg=1; total 8 cycles.
- beq, Zero=1 then Zero=0: In BRANCH, PCWrite=1 with PCSrc=01 for Zero=1, and PCWrite=0 for Zero=0. Both return to FETCH after 3 cycles.
- Op=000000, Funct=000000: Illegal pulses in DECODE, no RegWrite, next state FETCH.
- TIMEOUT=15, MemReady held 0 in FETCH: MemTimeout pulses on the 16th FETCH cycle with IRWrite/PCWrite never asserted. FETCH then restarts.
- rstn asserted mid-MEM on a sw: MemWrite drops immediately, and State=0 after release.
